// File: rtl/note_judge_pkg.sv
// Shared constants, lane state encoding and BCD arithmetic for the note judge.
package note_judge_pkg;

  localparam int unsigned LANES = 3;
  localparam int unsigned POS_W = 10;

  // Hit window and perfect sub-window on the note centre Y, bounds inclusive.
  localparam logic [POS_W-1:0] HIT_LO  = 10'd410;
  localparam logic [POS_W-1:0] HIT_HI  = 10'd450;
  localparam logic [POS_W-1:0] PERF_LO = 10'd425;
  localparam logic [POS_W-1:0] PERF_HI = 10'd435;

  // Points per judged hit; the sum over three lanes fits in four bits.
  localparam logic [3:0] PTS_PERFECT = 4'd3;
  localparam logic [3:0] PTS_GOOD    = 4'd1;

  // Consecutive equal tick samples needed before a button's stable value moves.
  localparam int unsigned DEB_N = 3;

  typedef enum logic [1:0] {
    LANE_WAIT = 2'd0,
    LANE_OPEN = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

  // Add a small binary value to a four-digit BCD number; clamps at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] val, input logic [3:0] add);
    logic [15:0] res;
    logic [4:0]  acc;
    logic [4:0]  cin;
    res = 16'h0000;
    cin = {1'b0, add};
    for (int d = 0; d < 4; d++) begin
      acc = {1'b0, val[d*4 +: 4]} + cin;
      if (acc > 5'd9) begin
        res[d*4 +: 4] = 4'(acc - 5'd10);
        cin           = 5'd1;
      end else begin
        res[d*4 +: 4] = acc[3:0];
        cin           = 5'd0;
      end
    end
    if (cin != 5'd0) begin
      res = 16'h9999;
    end
    return res;
  endfunction

endpackage

// File: rtl/note_judge_lane_debounce.sv
// Tick-sampled button debouncer: the stable value follows the raw input only
// after DEB_N consecutive tick samples disagree with it. press is a single
// tick-cycle pulse on the stable 0->1 edge, produced combinationally so the
// lane logic can act on it in the same tick.
module lane_debounce
  import note_judge_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_N) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flip_s;

  // Count consecutive samples that differ from the stable value; flip on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    flip_s   = 1'b0;
    if (tick) begin
      if (raw != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = raw;
          cnt_d    = '0;
          flip_s   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Debouncer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = flip_s & raw;

endmodule

// File: rtl/note_judge.sv
// Rhythm-game note judge: debounces three lane buttons, runs a WAIT/OPEN/DONE
// judge per lane against the leading note's position, and keeps a BCD score
// plus current and best hit streaks. Everything advances only on tick.
module note_judge
  import note_judge_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        play,
  input  logic        clear,
  input  logic [2:0]  btn,
  input  logic [2:0]  lane_active,
  input  logic [9:0]  lane_pos_r,
  input  logic [9:0]  lane_pos_g,
  input  logic [9:0]  lane_pos_b,
  output logic [2:0]  hit,
  output logic [2:0]  miss,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

  logic [2:0]       press_s;
  logic [POS_W-1:0] pos_s [LANES];
  logic [2:0]       win_s;
  logic [2:0]       perf_s;
  logic [2:0]       past_s;
  logic [2:0]       bad_s;
  logic [3:0]       pts_s;
  logic [1:0]       nhits_s;
  logic [8:0]       combo_sum_s;

  lane_state_e      state_q [LANES];
  lane_state_e      state_d [LANES];
  logic [2:0]       hit_q;
  logic [2:0]       hit_d;
  logic [2:0]       miss_q;
  logic [2:0]       miss_d;
  logic [15:0]      score_q;
  logic [15:0]      score_d;
  logic [7:0]       combo_q;
  logic [7:0]       combo_d;
  logic [7:0]       max_q;
  logic [7:0]       max_d;

  // Lane index follows the button bit order: 2=R, 1=G, 0=B.
  assign pos_s[2] = lane_pos_r;
  assign pos_s[1] = lane_pos_g;
  assign pos_s[0] = lane_pos_b;

  lane_debounce u_deb_r (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .raw     (btn[2]),
    .press   (press_s[2])
  );

  lane_debounce u_deb_g (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .raw     (btn[1]),
    .press   (press_s[1])
  );

  lane_debounce u_deb_b (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .raw     (btn[0]),
    .press   (press_s[0])
  );

  // Classify each lane's leading note against the hit and perfect windows.
  always_comb begin
    win_s  = 3'b000;
    perf_s = 3'b000;
    past_s = 3'b000;
    for (int i = 0; i < LANES; i++) begin
      win_s[i]  = lane_active[i] && (pos_s[i] >= HIT_LO) && (pos_s[i] <= HIT_HI);
      perf_s[i] = (pos_s[i] >= PERF_LO) && (pos_s[i] <= PERF_HI);
      past_s[i] = !lane_active[i] || (pos_s[i] > HIT_HI);
    end
  end

  // Per-lane judge: window entry is checked before the press so both in one tick is a hit.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    bad_s  = 3'b000;
    pts_s  = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
    end
    if (tick) begin
      hit_d  = 3'b000;
      miss_d = 3'b000;
      for (int i = 0; i < LANES; i++) begin
        if (clear || !play) begin
          state_d[i] = LANE_WAIT;
        end else begin
          case (state_q[i])
            LANE_WAIT: begin
              if (win_s[i] && press_s[i]) begin
                hit_d[i]   = 1'b1;
                pts_s      = pts_s + (perf_s[i] ? PTS_PERFECT : PTS_GOOD);
                state_d[i] = LANE_DONE;
              end else if (win_s[i]) begin
                state_d[i] = LANE_OPEN;
              end else if (press_s[i]) begin
                bad_s[i]   = 1'b1;
                state_d[i] = LANE_WAIT;
              end else begin
                state_d[i] = LANE_WAIT;
              end
            end
            LANE_OPEN: begin
              if (press_s[i]) begin
                hit_d[i]   = 1'b1;
                pts_s      = pts_s + (perf_s[i] ? PTS_PERFECT : PTS_GOOD);
                state_d[i] = LANE_DONE;
              end else if (past_s[i]) begin
                miss_d[i]  = 1'b1;
                state_d[i] = LANE_WAIT;
              end else begin
                state_d[i] = LANE_OPEN;
              end
            end
            LANE_DONE: begin
              if (past_s[i]) begin
                state_d[i] = LANE_WAIT;
              end else begin
                state_d[i] = LANE_DONE;
              end
            end
            default: begin
              state_d[i] = LANE_WAIT;
            end
          endcase
        end
      end
    end
  end

  // Score, streak and best streak for this tick; any miss or bad press zeroes the streak.
  always_comb begin
    nhits_s     = {1'b0, hit_d[0]} + {1'b0, hit_d[1]} + {1'b0, hit_d[2]};
    combo_sum_s = {1'b0, combo_q} + {7'd0, nhits_s};
    score_d     = score_q;
    combo_d     = combo_q;
    max_d       = max_q;
    if (tick) begin
      if (clear) begin
        score_d = 16'h0000;
        combo_d = 8'd0;
        max_d   = 8'd0;
      end else if (play) begin
        score_d = bcd_add_sat(score_q, pts_s);
        if ((miss_d | bad_s) != 3'b000) begin
          combo_d = 8'd0;
        end else if (combo_sum_s > 9'd255) begin
          combo_d = 8'd255;
        end else begin
          combo_d = combo_sum_s[7:0];
        end
        if (combo_d > max_q) begin
          max_d = combo_d;
        end else begin
          max_d = max_q;
        end
      end else begin
        score_d = score_q;
        combo_d = combo_q;
        max_d   = max_q;
      end
    end
  end

  // Judge state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= LANE_WAIT;
      end
      hit_q   <= 3'b000;
      miss_q  <= 3'b000;
      score_q <= 16'h0000;
      combo_q <= 8'd0;
      max_q   <= 8'd0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
      end
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
    end
  end

  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_q;

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: a directed vector table, hand-written corner sequences
// and a randomized run checked against a behavioural model of the game rules.
module tb_note_judge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        tick = 1'b0;
  logic        play = 1'b1;
  logic        clear = 1'b0;
  logic [2:0]  btn = 3'b000;
  logic [2:0]  lane_active = 3'b000;
  logic [9:0]  pr = 10'd0;
  logic [9:0]  pg = 10'd0;
  logic [9:0]  pb = 10'd0;
  logic [2:0]  hit;
  logic [2:0]  miss;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  note_judge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .play        (play),
    .clear       (clear),
    .btn         (btn),
    .lane_active (lane_active),
    .lane_pos_r  (pr),
    .lane_pos_g  (pg),
    .lane_pos_b  (pb),
    .hit         (hit),
    .miss        (miss),
    .score       (score),
    .combo       (combo),
    .max_combo   (max_combo)
  );

  // ---------------- behavioural model ----------------
  bit         m_stable [3];
  int         m_seen   [3];
  logic [2:0] m_last   [3];
  int         m_st     [3];   // 0 waiting, 1 note open, 2 already judged
  int         m_score, m_combo, m_max;
  logic [2:0] m_hit, m_miss;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_stable[i] = 1'b0; m_seen[i] = 0; m_last[i] = 3'b000; m_st[i] = 0;
    end
    m_score = 0; m_combo = 0; m_max = 0; m_hit = 3'b000; m_miss = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] b, input logic [2:0] a, input logic [9:0] p2,
                            input logic [9:0] p1, input logic [9:0] p0, input logic pl, input logic cl);
    logic [9:0] p [3];
    bit pz [3];
    bit inwin, perf, gone, brk;
    int pts, nh;
    p[2] = p2; p[1] = p1; p[0] = p0;
    // a button's level is believed once its last three samples all disagree with it
    for (int i = 0; i < 3; i++) begin
      m_last[i] = {m_last[i][1:0], b[i]};
      if (m_seen[i] < 3) m_seen[i]++;
      pz[i] = 1'b0;
      if (m_seen[i] == 3 && m_last[i] == (m_stable[i] ? 3'b000 : 3'b111)) begin
        pz[i] = !m_stable[i];
        m_stable[i] = !m_stable[i];
      end
    end
    m_hit = 3'b000; m_miss = 3'b000; pts = 0; nh = 0; brk = 1'b0;
    if (cl) begin
      m_score = 0; m_combo = 0; m_max = 0;
      for (int i = 0; i < 3; i++) m_st[i] = 0;
    end else if (!pl) begin
      for (int i = 0; i < 3; i++) m_st[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        inwin = a[i] && p[i] >= 10'd410 && p[i] <= 10'd450;
        perf  = p[i] >= 10'd425 && p[i] <= 10'd435;
        gone  = !a[i] || p[i] > 10'd450;
        if ((m_st[i] == 0 && inwin && pz[i]) || (m_st[i] == 1 && pz[i])) begin
          m_hit[i] = 1'b1; nh++; pts += perf ? 3 : 1; m_st[i] = 2;
        end else if (m_st[i] == 0 && inwin) begin
          m_st[i] = 1;
        end else if (m_st[i] == 0 && pz[i]) begin
          brk = 1'b1;
        end else if (m_st[i] == 1 && gone) begin
          m_miss[i] = 1'b1; m_st[i] = 0;
        end else if (m_st[i] == 2 && gone) begin
          m_st[i] = 0;
        end
      end
      m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
      if (brk || m_miss != 3'b000) m_combo = 0;
      else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
      if (m_combo > m_max) m_max = m_combo;
    end
  endtask

  // ---------------- drive and compare ----------------
  task automatic check(input string name, input logic [2:0] eh, input logic [2:0] em,
                       input logic [15:0] es, input logic [7:0] ec, input logic [7:0] emx);
    n_vec++;
    if (hit !== eh || miss !== em || score !== es || combo !== ec || max_combo !== emx) begin
      n_bad++;
      $display("FAIL %s: got hit=%b miss=%b score=%h combo=%0d max=%0d, expected hit=%b miss=%b score=%h combo=%0d max=%0d",
               name, hit, miss, score, combo, max_combo, eh, em, es, ec, emx);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_hit, m_miss, to_bcd(m_score), 8'(m_combo), 8'(m_max));
  endtask

  task automatic drive_tick(input logic [2:0] b, input logic [2:0] a, input logic [9:0] p2,
                            input logic [9:0] p1, input logic [9:0] p0, input logic pl, input logic cl);
    @(negedge clk);
    btn = b; lane_active = a; pr = p2; pg = p1; pb = p0; play = pl; clear = cl; tick = 1'b1;
    @(posedge clk);
    #1;
    model_step(b, a, p2, p1, p0, pl, cl);
  endtask

  // A non-tick cycle with noisy inputs must leave every output untouched.
  task automatic idle_cycle(input string name);
    @(negedge clk);
    tick = 1'b0; btn = 3'($urandom); clear = 1'($urandom); play = 1'($urandom);
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0; clear = 1'b0; play = 1'b1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("reset", 3'b000, 3'b000, 16'h0000, 8'd0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic round(input logic [2:0] mask, input logic [9:0] p2, input logic [9:0] p1, input logic [9:0] p0);
    repeat (3) begin drive_tick(mask, mask, p2, p1, p0, 1'b1, 1'b0); check_model("grind"); end
    repeat (3) begin drive_tick(3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0); check_model("grind"); end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  b;
    logic [2:0]  a;
    logic [9:0]  p2, p1, p0;
    logic        cl;
    logic [2:0]  eh, em;
    logic [15:0] es;
    logic [7:0]  ec, emx;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [2:0] b, input logic [2:0] a, input int p2, input int p1,
                              input int p0, input logic cl, input logic [2:0] eh, input logic [2:0] em,
                              input logic [15:0] es, input int ec, input int emx);
    vec_t v;
    v.b = b; v.a = a; v.p2 = 10'(p2); v.p1 = 10'(p1); v.p0 = 10'(p0); v.cl = cl;
    v.eh = eh; v.em = em; v.es = es; v.ec = 8'(ec); v.emx = 8'(emx);
    return v;
  endfunction

  logic [9:0] rp [3];
  logic [2:0] ra, rb;

  initial begin
    // R perfect hit after three held samples
    tbl.push_back(mk(3'b100, 3'b100, 430, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0000, 0, 0));
    tbl.push_back(mk(3'b100, 3'b100, 430, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0000, 0, 0));
    tbl.push_back(mk(3'b100, 3'b100, 430, 0, 0, 1'b0, 3'b100, 3'b000, 16'h0003, 1, 1));
    tbl.push_back(mk(3'b100, 3'b000, 430, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0003, 1, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0003, 1, 1));
    // clear, then G good hit at 412 and B slipping past 450 unpressed
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b1, 3'b000, 3'b000, 16'h0000, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 0, 412, 0, 1'b0, 3'b000, 3'b000, 16'h0000, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 0, 412, 0, 1'b0, 3'b000, 3'b000, 16'h0000, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 0, 412, 0, 1'b0, 3'b010, 3'b000, 16'h0001, 1, 1));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0001, 1, 1));
    tbl.push_back(mk(3'b000, 3'b001, 0, 0, 440, 1'b0, 3'b000, 3'b000, 16'h0001, 1, 1));
    tbl.push_back(mk(3'b000, 3'b001, 0, 0, 451, 1'b0, 3'b000, 3'b001, 16'h0001, 0, 1));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0001, 0, 1));
    // all three lanes perfect in one tick
    tbl.push_back(mk(3'b111, 3'b111, 430, 430, 430, 1'b0, 3'b000, 3'b000, 16'h0001, 0, 1));
    tbl.push_back(mk(3'b111, 3'b111, 430, 430, 430, 1'b0, 3'b000, 3'b000, 16'h0001, 0, 1));
    tbl.push_back(mk(3'b111, 3'b111, 430, 430, 430, 1'b0, 3'b111, 3'b000, 16'h0010, 3, 3));
    tbl.push_back(mk(3'b111, 3'b000, 430, 430, 430, 1'b0, 3'b000, 3'b000, 16'h0010, 3, 3));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 3, 3));
    // bounce 1,0,1,1,1 on R with no note: one bad press on the last sample
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 3, 3));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 3, 3));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 3, 3));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 3, 3));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 0, 3));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 0, 3));
    // press lands on the same tick the note enters the window
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 0, 3));
    tbl.push_back(mk(3'b100, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0010, 0, 3));
    tbl.push_back(mk(3'b100, 3'b100, 428, 0, 0, 1'b0, 3'b100, 3'b000, 16'h0013, 1, 3));
    tbl.push_back(mk(3'b000, 3'b000, 0, 0, 0, 1'b0, 3'b000, 3'b000, 16'h0013, 1, 3));
    // lower window edge: 409 outside, 410 a good hit
    tbl.push_back(mk(3'b010, 3'b010, 0, 409, 0, 1'b0, 3'b000, 3'b000, 16'h0013, 1, 3));
    tbl.push_back(mk(3'b010, 3'b010, 0, 409, 0, 1'b0, 3'b000, 3'b000, 16'h0013, 1, 3));
    tbl.push_back(mk(3'b010, 3'b010, 0, 410, 0, 1'b0, 3'b010, 3'b000, 16'h0014, 2, 3));
    tbl.push_back(mk(3'b000, 3'b010, 0, 450, 0, 1'b0, 3'b000, 3'b000, 16'h0014, 2, 3));
    tbl.push_back(mk(3'b000, 3'b010, 0, 451, 0, 1'b0, 3'b000, 3'b000, 16'h0014, 2, 3));
    // upper window edge: 450 still open, 451 a miss
    tbl.push_back(mk(3'b000, 3'b001, 0, 0, 450, 1'b0, 3'b000, 3'b000, 16'h0014, 2, 3));
    tbl.push_back(mk(3'b000, 3'b001, 0, 0, 450, 1'b0, 3'b000, 3'b000, 16'h0014, 2, 3));
    tbl.push_back(mk(3'b000, 3'b001, 0, 0, 451, 1'b0, 3'b000, 3'b001, 16'h0014, 0, 3));

    do_reset();
    foreach (tbl[k]) begin
      drive_tick(tbl[k].b, tbl[k].a, tbl[k].p2, tbl[k].p1, tbl[k].p0, 1'b1, tbl[k].cl);
      check($sformatf("table[%0d]", k), tbl[k].eh, tbl[k].em, tbl[k].es, tbl[k].ec, tbl[k].emx);
      idle_cycle($sformatf("table_hold[%0d]", k));
    end

    // reset while R is open, release with the note already past the window
    do_reset();
    drive_tick(3'b000, 3'b100, 10'd430, 10'd0, 10'd0, 1'b1, 1'b0);
    check("open_before_reset", 3'b000, 3'b000, 16'h0000, 8'd0, 8'd0);
    do_reset();
    drive_tick(3'b000, 3'b100, 10'd460, 10'd0, 10'd0, 1'b1, 1'b0);
    check("no_miss_after_reset", 3'b000, 3'b000, 16'h0000, 8'd0, 8'd0);
    // press while play is low is lost; the note is later missed
    repeat (3) begin
      drive_tick(3'b100, 3'b100, 10'd430, 10'd0, 10'd0, 1'b0, 1'b0);
      check("play_low_no_hit", 3'b000, 3'b000, 16'h0000, 8'd0, 8'd0);
    end
    drive_tick(3'b100, 3'b100, 10'd430, 10'd0, 10'd0, 1'b1, 1'b0);
    check("held_btn_no_hit", 3'b000, 3'b000, 16'h0000, 8'd0, 8'd0);
    drive_tick(3'b100, 3'b000, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0);
    check("late_miss", 3'b000, 3'b100, 16'h0000, 8'd0, 8'd0);

    // score and streak saturation
    do_reset();
    for (int r = 0; r < 1110; r++) round(3'b111, 10'd430, 10'd430, 10'd430);
    round(3'b111, 10'd430, 10'd430, 10'd440);
    round(3'b100, 10'd412, 10'd0, 10'd0);
    check("sat_pre", 3'b000, 3'b000, 16'h9998, 8'd255, 8'd255);
    repeat (2) begin drive_tick(3'b100, 3'b100, 10'd430, 10'd0, 10'd0, 1'b1, 1'b0); check_model("sat_arm"); end
    drive_tick(3'b100, 3'b100, 10'd430, 10'd0, 10'd0, 1'b1, 1'b0);
    check("sat_9999", 3'b100, 3'b000, 16'h9999, 8'd255, 8'd255);
    repeat (3) begin drive_tick(3'b000, 3'b000, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0); check_model("sat_rel"); end
    repeat (2) begin drive_tick(3'b100, 3'b100, 10'd430, 10'd0, 10'd0, 1'b1, 1'b0); check_model("sat_arm"); end
    drive_tick(3'b100, 3'b100, 10'd430, 10'd0, 10'd0, 1'b1, 1'b0);
    check("sat_hold", 3'b100, 3'b000, 16'h9999, 8'd255, 8'd255);

    // randomized notes, buttons, play and clear against the model
    do_reset();
    ra = 3'b111; rb = 3'b000;
    for (int i = 0; i < 3; i++) rp[i] = 10'(395 + 7 * i);
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (rp[i] > 10'd465) begin
          rp[i] = 10'(395 + $urandom_range(0, 10));
          ra[i] = ($urandom_range(0, 3) != 0);
        end else begin
          rp[i] = rp[i] + 10'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 19) == 0) ra[i] = ~ra[i];
        if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
      end
      drive_tick(rb, ra, rp[2], rp[1], rp[0], ($urandom_range(0, 29) != 0), ($urandom_range(0, 99) == 0));
      check_model("random");
      if ($urandom_range(0, 3) == 0) idle_cycle("random_hold");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
